// File: rtl/briscv_loader_pkg.sv
// Shared definitions for the BRISC-V boot-time program loader:
// loader state encodings and the boot frame layout.
package briscv_loader_pkg;

  typedef enum logic [2:0] {
    LDR_HDR   = 3'd0,
    LDR_DATA  = 3'd1,
    LDR_ENTRY = 3'd2,
    LDR_START = 3'd3,
    LDR_RUN   = 3'd4,
    LDR_ERROR = 3'd5
  } ldr_state_e;

  // A frame is one word-count header, N program words, then one entry PC per core.
  localparam int unsigned LDR_HDR_WORDS = 1;

  function automatic int unsigned ldr_frame_words(input int unsigned n, input int unsigned cores);
    return LDR_HDR_WORDS + n + cores;
  endfunction

endpackage

// File: rtl/briscv_program_loader_if.sv
// Valid/ready word stream that carries a boot frame into the program loader.
interface briscv_program_loader_if #(
  parameter int DATA_WIDTH = 32
) ();

  logic                  load_valid;
  logic                  load_ready;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_last;

  modport master (
    output load_valid,
    output load_data,
    output load_last,
    input  load_ready
  );

  modport slave (
    input  load_valid,
    input  load_data,
    input  load_last,
    output load_ready
  );

endinterface

// File: rtl/briscv_program_loader.sv
// Boot loader for the multi-core BRISC-V system: writes a framed program into the
// shared instruction BRAM, captures one entry PC per core, then releases the cores.
module briscv_program_loader
  import briscv_loader_pkg::*;
#(
  parameter int NUM_CORES        = 2,
  parameter int DATA_WIDTH       = 32,
  parameter int ADDRESS_BITS     = 32,
  parameter int MEM_ADDRESS_BITS = 14
) (
  input  logic                              clock,
  input  logic                              reset,
  briscv_program_loader_if.slave            load,
  input  logic                              reload,
  output logic                              mem_we,
  output logic [MEM_ADDRESS_BITS-1:0]       mem_addr,
  output logic [DATA_WIDTH-1:0]             mem_wdata,
  output logic [NUM_CORES*ADDRESS_BITS-1:0] program_address,
  output logic                              start,
  output logic                              core_hold,
  output logic                              error
);

  localparam int ENTRY_IDX_BITS = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam int COUNT_BITS     = MEM_ADDRESS_BITS + 1;
  localparam logic [DATA_WIDTH:0] MAX_WORDS =
    {{DATA_WIDTH{1'b0}}, 1'b1} << MEM_ADDRESS_BITS;

  ldr_state_e state_q;
  ldr_state_e state_d;

  // Counters are one bit wider than the BRAM address so a full 2**MEM_ADDRESS_BITS
  // program can be expressed without wrapping the index back to zero.
  logic [COUNT_BITS-1:0]     words_q;
  logic [COUNT_BITS-1:0]     word_idx_q;
  logic [COUNT_BITS-1:0]     word_idx_next;
  logic [ENTRY_IDX_BITS-1:0] entry_idx_q;

  logic                    ready;
  logic                    xfer;
  logic                    hdr_take;
  logic                    write_en;
  logic                    capture;
  logic                    hdr_too_big;
  logic                    hdr_is_zero;
  logic                    entry_final;
  logic [ADDRESS_BITS-1:0] entry_word;

  assign word_idx_next = word_idx_q + 1'b1;
  assign hdr_too_big   = {1'b0, load.load_data} > MAX_WORDS;
  assign hdr_is_zero   = (load.load_data == '0);
  assign entry_final   = (entry_idx_q == ENTRY_IDX_BITS'(NUM_CORES - 1));
  assign entry_word    = ADDRESS_BITS'(load.load_data);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= LDR_HDR;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    hdr_take = 1'b0;
    write_en = 1'b0;
    capture  = 1'b0;
    ready    = (state_q == LDR_HDR) || (state_q == LDR_DATA) || (state_q == LDR_ENTRY);
    xfer     = ready && load.load_valid;

    // Only the final entry word may carry load_last; any disagreement is a framing fault
    // and the offending word is dropped.
    case (state_q)
      LDR_HDR: begin
        if (xfer) begin
          if (load.load_last || hdr_too_big) begin
            state_d = LDR_ERROR;
          end else if (hdr_is_zero) begin
            state_d = LDR_ENTRY;
          end else begin
            state_d  = LDR_DATA;
            hdr_take = 1'b1;
          end
        end
      end
      LDR_DATA: begin
        if (xfer) begin
          if (load.load_last) begin
            state_d = LDR_ERROR;
          end else begin
            write_en = 1'b1;
            if (word_idx_next == words_q) begin
              state_d = LDR_ENTRY;
            end
          end
        end
      end
      LDR_ENTRY: begin
        if (xfer) begin
          if (load.load_last != entry_final) begin
            state_d = LDR_ERROR;
          end else begin
            capture = 1'b1;
            if (entry_final) begin
              state_d = LDR_START;
            end
          end
        end
      end
      LDR_START: begin
        state_d = LDR_RUN;
      end
      LDR_RUN: begin
        if (reload) begin
          state_d = LDR_HDR;
        end
      end
      LDR_ERROR: begin
        if (reload) begin
          state_d = LDR_HDR;
        end
      end
      default: begin
        state_d = LDR_HDR;
      end
    endcase
  end

  assign load.load_ready = ready;
  assign start           = (state_q == LDR_START);
  assign core_hold       = !((state_q == LDR_START) || (state_q == LDR_RUN));
  assign error           = (state_q == LDR_ERROR);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      words_q         <= '0;
      word_idx_q      <= '0;
      entry_idx_q     <= '0;
      mem_we          <= 1'b0;
      mem_addr        <= '0;
      mem_wdata       <= '0;
      program_address <= '0;
    end else begin
      mem_we <= write_en;

      if (state_q == LDR_HDR) begin
        word_idx_q  <= '0;
        entry_idx_q <= '0;
      end

      if (hdr_take) begin
        words_q <= load.load_data[COUNT_BITS-1:0];
      end

      if (write_en) begin
        mem_addr   <= word_idx_q[MEM_ADDRESS_BITS-1:0];
        mem_wdata  <= load.load_data;
        word_idx_q <= word_idx_next;
      end

      if (capture) begin
        entry_idx_q <= entry_idx_q + 1'b1;
      end

      for (int i = 0; i < NUM_CORES; i++) begin
        if (capture && (entry_idx_q == ENTRY_IDX_BITS'(i))) begin
          program_address[i*ADDRESS_BITS +: ADDRESS_BITS] <= entry_word;
        end
      end
    end
  end

endmodule
